// File: rtl/lcd_hex_writer.sv
// HD44780 8-bit bus writer: power-up delay and init commands after reset, then a
// one-line "LL:HHHHHHHH" frame (source label + 8 hex digits) per accepted update.
module lcd_hex_writer #(
    parameter int SETUP_CYCLES        = 4,
    parameter int E_PULSE_CYCLES      = 25,
    parameter int CMD_WAIT_CYCLES     = 2500,
    parameter int CLEAR_WAIT_CYCLES   = 100000,
    parameter int POWERUP_WAIT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] to_lcd,
    input  logic [1:0]  sel,
    input  logic        update,
    output logic        busy,
    output logic        done,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_data
);
    localparam int MAX_A   = (POWERUP_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int MAX_B   = (CMD_WAIT_CYCLES > E_PULSE_CYCLES) ? CMD_WAIT_CYCLES : E_PULSE_CYCLES;
    localparam int MAX_C   = (MAX_B > SETUP_CYCLES) ? MAX_B : SETUP_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST   = CW'(E_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LAST     = CW'(CMD_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LAST   = CW'(CLEAR_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] POWERUP_LAST = CW'(POWERUP_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {ST_POWERUP, ST_INIT, ST_IDLE, ST_ADDR, ST_CHAR} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [31:0]   val_q, val_d;
    logic [1:0]    lab_q, lab_d;
    logic          rs_q, rs_d;
    logic          e_q, e_d;
    logic [7:0]    data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] wait_last;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] char_byte(input logic [3:0] i, input logic [31:0] v,
                                             input logic [1:0] l);
        logic [3:0] nib;
        nib = 4'h0;
        for (int unsigned n = 0; n < 8; n++) begin
            if (i == 4'(n + 3)) nib = v[28 - 4 * n +: 4];
        end
        case (i)
            4'd0: begin
                case (l)
                    2'b00:   char_byte = 8'h52;
                    2'b01:   char_byte = 8'h44;
                    2'b10:   char_byte = 8'h49;
                    default: char_byte = 8'h41;
                endcase
            end
            4'd1: begin
                case (l)
                    2'b00:   char_byte = 8'h44;
                    2'b11:   char_byte = 8'h4C;
                    default: char_byte = 8'h41;
                endcase
            end
            4'd2:    char_byte = 8'h3A;
            default: char_byte = {4'h0, nib} + ((nib < 4'd10) ? 8'h30 : 8'h37);
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        val_d     = val_q;
        lab_d     = lab_q;
        rs_d      = rs_q;
        e_d       = e_q;
        data_d    = data_q;
        done_d    = 1'b0;
        // Only the clear command needs the long settle time.
        wait_last = (!rs_q && data_q == 8'h01) ? CLEAR_LAST : CMD_LAST;
        case (state_q)
            ST_POWERUP: begin
                if (cnt_q == POWERUP_LAST) begin
                    state_d = ST_INIT;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rs_d    = 1'b0;
                    data_d  = init_byte(2'd0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE: begin
                if (update) begin
                    val_d   = to_lcd;
                    lab_d   = sel;
                    state_d = ST_ADDR;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                    rs_d    = 1'b0;
                    data_d  = 8'h80;
                end
            end
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        if (cnt_q == SETUP_LAST) begin
                            phase_d = PH_PULSE;
                            cnt_d   = '0;
                            e_d     = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    PH_PULSE: begin
                        if (cnt_q == PULSE_LAST) begin
                            phase_d = PH_WAIT;
                            cnt_d   = '0;
                            e_d     = 1'b0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        if (cnt_q == wait_last) begin
                            cnt_d   = '0;
                            phase_d = PH_SETUP;
                            idx_d   = idx_q + 4'd1;
                            case (state_q)
                                ST_INIT: begin
                                    if (idx_q == 4'd3) state_d = ST_IDLE;
                                    else               data_d  = init_byte(idx_q[1:0] + 2'd1);
                                end
                                ST_ADDR: begin
                                    state_d = ST_CHAR;
                                    idx_d   = '0;
                                    rs_d    = 1'b1;
                                    data_d  = char_byte(4'd0, val_q, lab_q);
                                end
                                default: begin
                                    if (idx_q == 4'd10) begin
                                        state_d = ST_IDLE;
                                        done_d  = 1'b1;
                                    end else begin
                                        data_d = char_byte(idx_q + 4'd1, val_q, lab_q);
                                    end
                                end
                            endcase
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                endcase
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_POWERUP;
            phase_q <= PH_SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            lab_q   <= '0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            lab_q   <= lab_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = e_q;
    assign lcd_data = data_q;

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Bench for lcd_hex_writer: a waveform model expanded from the byte sequence is
// compared every cycle, plus directed checks of strobed bytes and timing.
module tb_lcd_hex_writer;
    localparam int S   = 1;
    localparam int EP  = 2;
    localparam int CMW = 3;
    localparam int CLR = 10;
    localparam int PW  = 20;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic [31:0] to_lcd = '0;
    logic [1:0]  sel    = '0;
    logic        update = 1'b0;
    logic        busy, done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]  lcd_data;

    int total = 0;
    int bad   = 0;

    lcd_hex_writer #(
        .SETUP_CYCLES(S),
        .E_PULSE_CYCLES(EP),
        .CMD_WAIT_CYCLES(CMW),
        .CLEAR_WAIT_CYCLES(CLR),
        .POWERUP_WAIT_CYCLES(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .to_lcd(to_lcd), .sel(sel), .update(update),
        .busy(busy), .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       e;
        logic       rs;
        logic [7:0] data;
    } exp_t;

    localparam exp_t RST = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    exp_t       cur;
    exp_t       q[$];
    logic [8:0] cap[$];
    bit         chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] cap_at(input int i);
        return (i < cap.size()) ? cap[i] : 9'h1FF;
    endfunction

    // One byte on the bus: setup, strobe, then settle time.
    function automatic void push_byte(input logic rs, input logic [7:0] d);
        exp_t x;
        int   w = (!rs && d == 8'h01) ? CLR : CMW;
        x.busy = 1'b1; x.done = 1'b0; x.rs = rs; x.data = d;
        x.e = 1'b0; repeat (S)  q.push_back(x);
        x.e = 1'b1; repeat (EP) q.push_back(x);
        x.e = 1'b0; repeat (w)  q.push_back(x);
    endfunction

    function automatic void build_init();
        q.delete();
        repeat (PW - 1) q.push_back(RST);
        push_byte(1'b0, 8'h38);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h01);
    endfunction

    function automatic void push_frame(input logic [31:0] v, input logic [1:0] s);
        string hex = "0123456789ABCDEF";
        string lab;
        exp_t  x;
        case (s)
            2'b00:   lab = "RD";
            2'b01:   lab = "DA";
            2'b10:   lab = "IA";
            default: lab = "AL";
        endcase
        push_byte(1'b0, 8'h80);
        push_byte(1'b1, lab[0]);
        push_byte(1'b1, lab[1]);
        push_byte(1'b1, 8'h3A);
        for (int i = 0; i < 8; i++) push_byte(1'b1, hex[int'(v[31 - 4 * i -: 4])]);
        x = '{1'b0, 1'b1, 1'b0, 1'b1, hex[int'(v[3:0])]};
        q.push_back(x);
    endfunction

    initial begin
        cur = RST;
        build_init();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cur = RST;
                build_init();
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else if (update) begin
                push_frame(to_lcd, sel);
                cur = q.pop_front();
            end else begin
                cur.busy = 1'b0;
                cur.done = 1'b0;
                cur.e    = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en)
                check("cycle", {busy, done, lcd_e, lcd_rs, lcd_rw, lcd_data},
                      {cur.busy, cur.done, cur.e, cur.rs, 1'b0, cur.data});
        end
    end

    always @(posedge lcd_e) cap.push_back({lcd_rs, lcd_data});

    task automatic do_init(input string tag);
        int n = 0;
        cap.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (busy && n < 200);
        check({tag, "_len"}, n, 51);
        repeat (10) @(negedge clk);
        check({tag, "_nbytes"}, cap.size(), 4);
        check({tag, "_b0"}, cap_at(0), 9'h038);
        check({tag, "_b1"}, cap_at(1), 9'h00C);
        check({tag, "_b2"}, cap_at(2), 9'h006);
        check({tag, "_b3"}, cap_at(3), 9'h001);
    endtask

    task automatic run_frame(input logic [31:0] v, input logic [1:0] s, input string txt,
                             input bit disturb);
        int n = 0;
        @(negedge clk);
        cap.delete();
        to_lcd = v; sel = s; update = 1'b1;
        @(posedge clk); #1;
        update = 1'b0;
        check("acc_busy", busy, 1);
        check("acc_e", lcd_e, 0);
        check("acc_cmd", {lcd_rs, lcd_data}, 9'h080);
        do begin
            @(posedge clk); #1; n++;
            if (disturb && n == 20) begin
                to_lcd = '1; update = 1'b1;
            end
            if (disturb && n == 21) update = 1'b0;
        end while (!done && n < 300);
        check("frame_len", n, 72);
        check("frame_nbytes", cap.size(), 12);
        check("frame_cmd", cap_at(0), 9'h080);
        for (int i = 0; i < 11; i++)
            check($sformatf("frame_char%0d", i), cap_at(i + 1), {1'b1, txt[i]});
        repeat (8) @(negedge clk);
        check("idle_after", {busy, done}, 2'b00);
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_e", lcd_e, 0);
        check("rst_rs_rw", {lcd_rs, lcd_rw}, 2'b00);
        check("rst_data", lcd_data, 8'h00);
        repeat (3) @(negedge clk);
        do_init("init");

        run_frame(32'hDEADBEEF, 2'b11, "AL:DEADBEEF", 1'b0);
        run_frame(32'h0123A9F0, 2'b00, "RD:0123A9F0", 1'b0);
        run_frame(32'h0123A9F0, 2'b01, "DA:0123A9F0", 1'b0);
        run_frame(32'h0123A9F0, 2'b10, "IA:0123A9F0", 1'b0);
        run_frame(32'h12345678, 2'b10, "IA:12345678", 1'b1);

        // Back-to-back frames with update held high.
        @(negedge clk);
        to_lcd = 32'hCAFEF00D; sel = 2'b01; update = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!done && n < 300);
        check("b2b_first_len", n, 73);
        @(posedge clk); #1;
        check("b2b_next_busy", {busy, done}, 2'b10);
        check("b2b_next_cmd", {lcd_rs, lcd_data}, 9'h080);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!done && n < 300);
        update = 1'b0;
        check("b2b_second_len", n, 72);
        repeat (5) @(negedge clk);
        check("b2b_stop", busy, 0);

        // Async reset while E is high on CHAR[5].
        @(negedge clk);
        cap.delete();
        to_lcd = 32'h00C0FFEE; sel = 2'b00; update = 1'b1;
        @(posedge clk); #1;
        update = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (cap.size() < 7 && n < 300);
        check("ar_strobe", cap_at(6), 9'h143);
        check("ar_e_high", lcd_e, 1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_e", lcd_e, 0);
        check("ar_rs", lcd_rs, 0);
        check("ar_data", lcd_data, 8'h00);
        check("ar_busy", busy, 1);
        repeat (3) @(negedge clk);
        do_init("reinit");
        run_frame(32'h89ABCDEF, 2'b11, "AL:89ABCDEF", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lcd_hex_writer.md
# lcd_hex_writer

Sequential driver downstream of the LCD source-select mux. It takes the selected 32-bit word and the 2-bit select code, and writes a one-line frame to an HD44780-compatible character LCD over its 8-bit parallel bus. The frame is a 2-letter source label, a colon and 8 uppercase hex digits. On reset it runs the LCD power-up/init command sequence, then refreshes the display each time `update` is accepted.

## Interface
Parameters:
- `SETUP_CYCLES`, default 4: cycles RS/data are stable with E low before E rises.
- `E_PULSE_CYCLES`, default 25: E high width in cycles.
- `CMD_WAIT_CYCLES`, default 2500: wait after E falls, for every byte except clear.
- `CLEAR_WAIT_CYCLES`, default 100000: wait after E falls for the clear command (0x01).
- `POWERUP_WAIT_CYCLES`, default 1000000: idle delay after reset before the first init byte.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `to_lcd` input 32: value to display, sampled on accept.
- `sel` input 2: source code, sampled on accept. Label mapping: 00 "RD", 01 "DA", 10 "IA", 11 "AL".
- `update` input 1: refresh request, honoured only in IDLE.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `done` output 1: one-cycle pulse when a frame completes.
- `lcd_rs` output 1: 0 = command, 1 = data.
- `lcd_rw` output 1: tied 0 (write only).
- `lcd_e` output 1: enable strobe.
- `lcd_data` output 8: LCD bus byte.

## Operation
- Top states:
  - POWERUP: waits POWERUP_WAIT_CYCLES.
  - INIT: sends 4 commands in order: 0x38, 0x0C, 0x06, 0x01.
  - IDLE.
  - ADDR: sends command 0x80, the DDRAM line-0 column-0 address.
  - CHAR: sends 11 data bytes, index 0..10.
- Every byte uses three sub-phases:
  - SETUP: E=0, RS and data driven.
  - PULSE: E=1.
  - WAIT: E=0, RS and data held.
  - The phase counter reloads at each phase entry.
- Top-state transitions:
  - POWERUP → INIT[0].
  - INIT[3] WAIT end → IDLE.
  - IDLE with `update`=1 → ADDR.
  - ADDR → CHAR[0].
  - CHAR[10] WAIT end → IDLE.
- Accept in IDLE registers `to_lcd` and `sel` into a frame latch. Input changes mid-frame do not affect the current frame.
- Character bytes, in order:
  - Index 0–1: label ASCII from the latched `sel`.
  - Index 2: ':' (0x3A).
  - Index 3–10: latched nibbles [31:28] down to [3:0].
  - Nibble n maps to 0x30+n for n ≤ 9, and 0x37+n for n ≥ 10.
- `update` while busy is ignored and not queued. `update` held high in IDLE starts back-to-back frames.
- `lcd_rw` is constant 0.

## Timing
- Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `busy`=1, `done`=0. The FSM is in POWERUP with a cleared counter and frame latch.
- Reset asserted mid-frame or mid-init:
  - Outputs go to their reset values immediately, including E dropping without waiting for a clock.
  - The full power-up and init sequence reruns after release.
- Byte cost: SETUP_CYCLES + E_PULSE_CYCLES + WAIT cycles, where WAIT is CLEAR_WAIT_CYCLES for 0x01 and CMD_WAIT_CYCLES otherwise.
- Init-complete time: after reset release, IDLE (`busy`=0) is reached after POWERUP_WAIT + 4×(SETUP+E_PULSE) + 3×CMD_WAIT + CLEAR_WAIT cycles.
- Frame accept: `update` sampled high in IDLE at edge N.
  - `busy`=1 from edge N.
  - `lcd_rs`=0 and `lcd_data`=0x80 from edge N.
  - `lcd_e` rises at edge N+SETUP_CYCLES.
- Frame length: 12×(SETUP+E_PULSE+CMD_WAIT) cycles from accept to return to IDLE.
- Frame completion: `done`=1 for exactly the first cycle back in IDLE, coincident with `busy` falling. A new `update` may be accepted that same cycle.
- Output stability:
  - RS and data change only on entry to SETUP, never while E=1 or during WAIT.
  - E is glitch-free because it is registered.
- All phase counters must hold values up to max(POWERUP_WAIT_CYCLES, CLEAR_WAIT_CYCLES).

## Test plan
Bench parameters: SETUP=1, E_PULSE=2, CMD_WAIT=3, CLEAR_WAIT=10, POWERUP_WAIT=20.

- **Init sequence.** Release reset and leave `update` low. Required: E strobes capture 0x38, 0x0C, 0x06, 0x01 with RS=0; `busy` falls exactly 20+4×3+3×3+10 = 51 cycles after release; no further strobes occur.
- **Frame contents.** `update` pulse with `to_lcd`=0xDEADBEEF, `sel`=11. Required captured bytes: cmd 0x80, then data 'A','L',':','D','E','A','D','B','E','E','F'; `done` pulses once, 72 cycles after accept.
- **Label and digit coverage.** `to_lcd`=0x0123A9F0, `sel`=00, 01, 10 in turn. Required labels "RD", "DA", "IA"; digits "0123A9F0" in all three frames.
- **Input isolation.** Change `to_lcd` to 0xFFFFFFFF and pulse `update` during a frame for 0x12345678. Required: the frame still shows 0x12345678; no second frame starts.
- **Async reset mid-pulse.** Assert `rst_n`=0 while `lcd_e`=1 in CHAR[5], between clock edges. Required: `lcd_e`, `lcd_rs` and `lcd_data` go to 0 immediately with no clock edge; `busy`=1; after release the full init sequence repeats.
- **Back-to-back frames.** Hold `update`=1 continuously. Required: consecutive frames with the `done` cycle immediately followed by the next 0x80 setup, with no idle gap.
